// File: rtl/taus_pkg.sv
// Shared types and constants for the combined Tausworthe generator.
// Holds per-component shift/mask constants, seed minimums and helpers.
// No logic of its own; imported by taus_comp and taus_combined_gen.
package taus_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  localparam int unsigned MAX_COMP = 3;
  localparam int unsigned CNT_W    = 8;

  // Left shift applied before the feedback XOR.
  function automatic int unsigned comp_a(input int unsigned idx);
    case (idx)
      1:       return 13;
      2:       return 2;
      default: return 3;
    endcase
  endfunction

  // Right shift that extracts the feedback bits.
  function automatic int unsigned comp_b(input int unsigned idx);
    case (idx)
      1:       return 19;
      2:       return 25;
      default: return 11;
    endcase
  endfunction

  // Left shift applied to the masked state.
  function automatic int unsigned comp_c(input int unsigned idx);
    case (idx)
      1:       return 12;
      2:       return 4;
      default: return 17;
    endcase
  endfunction

  // Mask dropping the low bits that are not part of the recurrence.
  function automatic word_t comp_m(input int unsigned idx);
    case (idx)
      1:       return 32'hffff_fffe;
      2:       return 32'hffff_fff8;
      default: return 32'hffff_fff0;
    endcase
  endfunction

  // Smallest legal seed; anything below it would collapse the recurrence.
  // Each minimum is a single power of two, so it doubles as the bit to set.
  function automatic word_t seed_min(input int unsigned idx);
    case (idx)
      1:       return 32'd2;
      2:       return 32'd8;
      default: return 32'd16;
    endcase
  endfunction

  // Force a seed into the legal range by setting its minimum bit.
  function automatic word_t seed_fixup(input int unsigned idx, input word_t s);
    return (s < seed_min(idx)) ? (s | seed_min(idx)) : s;
  endfunction

endpackage

// File: rtl/taus_comp.sv
// One Tausworthe component: state register, one-step recurrence, seed fix-up.
// Latency: state updates one cycle after load/step.
// Backpressure: none; it steps only when the parent asserts step.
module taus_comp
  import taus_pkg::*;
#(
  parameter int unsigned IDX        = 1,
  parameter word_t       RESET_SEED = 32'hffff_ffff
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  step,
  input  word_t seed,
  output word_t comp_state
);

  localparam int unsigned SH_A        = comp_a(IDX);
  localparam int unsigned SH_B        = comp_b(IDX);
  localparam int unsigned SH_C        = comp_c(IDX);
  localparam word_t       MASK        = comp_m(IDX);
  localparam word_t       RESET_FIXED = seed_fixup(IDX, RESET_SEED);

  word_t feedback;
  word_t stepped;
  word_t seed_fixed;

  // Next state of the recurrence, all arithmetic wraps at 32 bits.
  always_comb begin
    feedback = ((comp_state << SH_A) ^ comp_state) >> SH_B;
    stepped  = ((comp_state & MASK) << SH_C) ^ feedback;
  end

  // Incoming seed pushed into the legal range before it is stored.
  always_comb begin
    seed_fixed = seed_fixup(IDX, seed);
  end

  // State register: a load beats a step when both are requested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      comp_state <= RESET_FIXED;
    end else if (load) begin
      comp_state <= seed_fixed;
    end else if (step) begin
      comp_state <= stepped;
    end
  end

endmodule

// File: rtl/taus_combined_gen.sv
// Combined Tausworthe generator: XOR of up to three components, MSBs out.
// Latency: WARMUP cycles after reset/seed, then one sample per cycle.
// Backpressure: sample held while out_valid && !out_ready; seeds always accepted.
module taus_combined_gen
  import taus_pkg::*;
#(
  parameter int unsigned NCOMP        = 3,
  parameter int unsigned WARMUP       = 1,
  parameter int unsigned OUT_WIDTH    = 32,
  parameter logic [95:0] DEFAULT_SEED = {32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 seed_valid,
  output logic                 seed_ready,
  input  logic [95:0]          seed_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 busy
);

  localparam state_t            START_STATE = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
  localparam logic [CNT_W-1:0]  WARMUP_CNT  = CNT_W'(WARMUP);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             load;
  logic             xfer;
  logic             step;
  word_t            comp_state [MAX_COMP];
  word_t            combined;

  // Components above NCOMP are not built and contribute zero to the XOR.
  for (genvar k = 0; k < MAX_COMP; k++) begin : g_comp
    if (k < NCOMP) begin : g_on
      taus_comp #(
        .IDX        (k + 1),
        .RESET_SEED (DEFAULT_SEED[32*k +: 32])
      ) u_comp (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .step       (step),
        .seed       (seed_data[32*k +: 32]),
        .comp_state (comp_state[k])
      );
    end else begin : g_off
      logic unused_seed_bits;
      assign unused_seed_bits = ^seed_data[32*k +: 32];
      assign comp_state[k]    = '0;
    end
  end

  // Combined word is the XOR of the live component states.
  always_comb begin
    combined = comp_state[0] ^ comp_state[1] ^ comp_state[2];
  end

  // Seeds are never refused; a transfer needs a valid sample and a ready sink.
  always_comb begin
    seed_ready = 1'b1;
    load       = seed_valid && seed_ready;
    out_valid  = (state == ST_RUN) && !rst;
    busy       = (state == ST_WARMUP);
    xfer       = out_valid && out_ready;
  end

  // Sample is the top OUT_WIDTH bits; narrower outputs drop the low bits.
  logic unused_combined;
  always_comb begin
    out_data        = combined[31 -: OUT_WIDTH];
    unused_combined = ^combined;
  end

  // State and warm-up counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= START_STATE;
      cnt   <= WARMUP_CNT;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state: a seed load restarts warm-up and suppresses any step;
  // warm-up steps every cycle; run steps only on a completed transfer.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    step       = 1'b0;
    if (load) begin
      state_next = START_STATE;
      cnt_next   = WARMUP_CNT;
    end else begin
      case (state)
        ST_WARMUP: begin
          step = 1'b1;
          if (cnt <= CNT_W'(1)) begin
            state_next = ST_RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
        ST_RUN: begin
          step = xfer;
        end
        default: begin
          state_next = START_STATE;
        end
      endcase
    end
  end

endmodule

// File: doc/taus_combined_gen.md
TAUS_COMBINED_GEN -- requirements
Module: taus_combined_gen

Interface
REQ-001 Parameter NCOMP, default 3: number of combined Tausworthe components, legal 1..3.
REQ-002 Parameter WARMUP, default 1: state steps discarded after reset or reseed, legal 0..255.
REQ-003 Parameter OUT_WIDTH, default 32: output width, legal 1..32.
REQ-004 Parameter DEFAULT_SEED, default {32'hffffffff, 32'hffffffff, 32'hffffffff}: reset seeds for components 3..1.
REQ-005 clk  input  1  clock.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 seed_valid  input  1  seed offer.
REQ-008 seed_ready  output  1  seed accepted when high with seed_valid.
REQ-009 seed_data  input  96  component seeds; bits [32k-1:32k-32] = component k.
REQ-010 out_valid  output  1  out_data holds a valid sample.
REQ-011 out_ready  input  1  consumer takes the sample.
REQ-012 out_data  output  OUT_WIDTH  sample: MSBs [31:32-OUT_WIDTH] of the combined word.
REQ-013 busy  output  1  high in WARMUP.

Function
REQ-014 Component k step: b = ((s << Ak) ^ s) >> Bk; s_next = ((s & Mk) << Ck) ^ b; all operations modulo 2^32.
REQ-015 Component constants (A,B,C,M):
- comp1: 13, 19, 12, 32'hfffffffe
- comp2: 2, 25, 4, 32'hfffffff8
- comp3: 3, 11, 17, 32'hfffffff0
REQ-016 Only components 1..NCOMP exist; combined word = XOR of their current state registers.
REQ-017 Seed fix-up on every load, reset included:
- comp1 < 2 → bit1 set
- comp2 < 8 → bit3 set
- comp3 < 16 → bit4 set
REQ-018 States: WARMUP and RUN.
REQ-019 WARMUP: all components step every cycle; counter counts WARMUP steps; out_valid=0, busy=1; afterwards → RUN.
REQ-020 WARMUP=0: go directly to RUN; first sample equals the fixed-up seed XOR.
REQ-021 RUN: out_valid=1; out_data stable while out_valid && !out_ready.
REQ-022 RUN: on transfer (out_valid && out_ready), all components step once; next sample is visible the following cycle, so full throughput is 1 sample/cycle.
REQ-023 seed_ready=1 in every state; an accepted seed loads fixed-up seeds, reloads the counter and enters WARMUP (or RUN if WARMUP=0) next cycle.
REQ-024 Seed accept in the same cycle as a transfer: the transfer completes with the old sample; the seed load takes priority over the step.
REQ-025 Seed accept mid-WARMUP restarts warm-up from the new seed with the full count.
REQ-026 Unused seed_data bits for components above NCOMP are ignored.

Reset
REQ-027 On rst, asynchronously:
- states ← fixed-up DEFAULT_SEED
- counter ← WARMUP
- FSM ← WARMUP (RUN if WARMUP=0)
- out_valid=0, busy=1 (busy=0 if WARMUP=0)
REQ-028 rst asserted mid-stream discards any pending sample; the sequence restarts from DEFAULT_SEED.

Structure
REQ-029 Package taus_pkg holds:
- component constants A, B, C, M and seed minimums (2, 8, 16)
- FSM state typedef
- 32-bit word typedef
REQ-030 Sub-module taus_comp implements one component step (REQ-014) and its seed fix-up, parameterised by component index; it is instantiated NCOMP times.

Verification
REQ-031 NCOMP=1, WARMUP=1, reset seeds → first out_data=32'hffffe000; after one transfer → 32'hfe00007f.
REQ-032 Same config, out_ready held low 10 cycles → out_data stays 32'hffffe000 and out_valid stays 1.
REQ-033 WARMUP=0, NCOMP=3, seed load {0,0,0} → first sample = 32'h2^32'h8^32'h10 = 32'h0000001a.
REQ-034 WARMUP=4, seed accepted in the same cycle as a transfer → that transfer returns the old sample; out_valid low exactly 4 cycles; then the sample of the new seed stepped 4 times.
REQ-035 rst pulsed mid-stream → out_valid=0 immediately; the sequence then repeats REQ-031 values.
REQ-036 NCOMP=3, OUT_WIDTH=8, 10k transfers with out_ready random → each out_data equals bits [31:24] of a reference model's combined word; no stalled sample is lost or duplicated.
